// File: rtl/sdiv_pkg.sv
// Shared types for the signed-divide sequencer: FSM states and the result record.
// Result fields are sized for the widest supported operand; users take the low WIDTH bits.
package sdiv_pkg;

    localparam int SDIV_W_MAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_FIXUP,
        ST_HOLD
    } sdiv_state_e;

    typedef struct packed {
        logic [SDIV_W_MAX-1:0] quo;
        logic [SDIV_W_MAX-1:0] rem;
        logic                  dbz;
        logic                  ovf;
    } sdiv_result_t;

endpackage

// File: rtl/sdiv_sign_fix.sv
// Combinational sign handling around an unsigned divider: operand magnitudes on the
// way in, quotient/remainder negation plus divide-by-zero and overflow overrides on the way out.
module sdiv_sign_fix
    import sdiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             op_signed_i,
    output logic [WIDTH-1:0] mag_a_o,
    output logic [WIDTH-1:0] mag_b_o,
    input  logic [WIDTH-1:0] orig_a_i,
    input  logic             orig_b_neg_i,
    input  logic             orig_signed_i,
    input  logic [WIDTH-1:0] q_mag_i,
    input  logic [WIDTH-1:0] r_mag_i,
    input  logic             dbz_i,
    input  logic             ovf_i,
    output sdiv_result_t     res_o
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] quo_w;
    logic [WIDTH-1:0] rem_w;

    // Negating MIN wraps back to MIN, which is exactly its unsigned magnitude.
    assign mag_a_o = (op_signed_i && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
    assign mag_b_o = (op_signed_i && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;

    always_comb begin
        neg_q = orig_signed_i & (orig_a_i[WIDTH-1] ^ orig_b_neg_i);
        neg_r = orig_signed_i & orig_a_i[WIDTH-1];
        quo_w = neg_q ? -q_mag_i : q_mag_i;
        rem_w = neg_r ? -r_mag_i : r_mag_i;
        if (dbz_i) begin
            quo_w = '1;
            rem_w = orig_a_i;
        end else if (ovf_i) begin
            quo_w = MIN_VAL;
            rem_w = '0;
        end
        res_o     = '0;
        res_o.quo = SDIV_W_MAX'(quo_w);
        res_o.rem = SDIV_W_MAX'(rem_w);
        res_o.dbz = dbz_i;
        res_o.ovf = ovf_i;
    end

endmodule

// File: rtl/sdiv_sequencer.sv
// Sequencer wrapping an unsigned divider core to provide signed/unsigned division.
// Define SDIV_OVF_CHECK_EN to short-circuit signed MIN / -1 and report it on out_ovf.
module sdiv_sequencer
    import sdiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             core_start,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic             core_busy,
    input  logic             core_done,
    input  logic             core_valid,
    input  logic             core_dbz,
    input  logic [WIDTH-1:0] core_val,
    input  logic [WIDTH-1:0] core_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quo,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_dbz
`ifdef SDIV_OVF_CHECK_EN
    ,
    output logic             out_ovf
`endif
);

    sdiv_state_e      state_q;
    logic             in_ready_q;
    logic             core_start_q;
    logic [WIDTH-1:0] core_a_q;
    logic [WIDTH-1:0] core_b_q;
    logic [WIDTH-1:0] a_q;
    logic             b_neg_q;
    logic             signed_q;
    logic [WIDTH-1:0] qmag_q;
    logic [WIDTH-1:0] rmag_q;
    logic             dbz_q;
    logic             ovf_q;
    logic             out_valid_q;
    sdiv_result_t     res_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             is_ovf;
    sdiv_result_t     fix_res;

`ifdef SDIV_OVF_CHECK_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    assign is_ovf = in_signed && (in_a == MIN_VAL) && (in_b == {WIDTH{1'b1}});
    assign out_ovf = res_q.ovf;
`else
    assign is_ovf = 1'b0;
`endif

    sdiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_a_i        (in_a),
        .op_b_i        (in_b),
        .op_signed_i   (in_signed),
        .mag_a_o       (mag_a),
        .mag_b_o       (mag_b),
        .orig_a_i      (a_q),
        .orig_b_neg_i  (b_neg_q),
        .orig_signed_i (signed_q),
        .q_mag_i       (qmag_q),
        .r_mag_i       (rmag_q),
        .dbz_i         (dbz_q),
        .ovf_i         (ovf_q),
        .res_o         (fix_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            a_q          <= '0;
            b_neg_q      <= 1'b0;
            signed_q     <= 1'b0;
            qmag_q       <= '0;
            rmag_q       <= '0;
            dbz_q        <= 1'b0;
            ovf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            res_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        a_q        <= in_a;
                        b_neg_q    <= in_b[WIDTH-1];
                        signed_q   <= in_signed;
                        dbz_q      <= 1'b0;
                        ovf_q      <= is_ovf;
                        if (is_ovf) begin
                            state_q <= ST_FIXUP;
                        end else begin
                            state_q      <= ST_LAUNCH;
                            core_start_q <= 1'b1;
                            core_a_q     <= mag_a;
                            core_b_q     <= mag_b;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    core_start_q <= 1'b0;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        qmag_q  <= core_val;
                        rmag_q  <= core_rem;
                        dbz_q   <= core_dbz;
                        state_q <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    res_q       <= fix_res;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign core_start = core_start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign out_valid  = out_valid_q;
    assign out_quo    = res_q.quo[WIDTH-1:0];
    assign out_rem    = res_q.rem[WIDTH-1:0];
    assign out_dbz    = res_q.dbz;

    // Upper result bits beyond WIDTH and the core's status strobes are not needed here.
    logic unused_sigs;
    assign unused_sigs = ^{res_q, fix_res, core_busy, core_valid};

endmodule

// File: tb/tb_sdiv_sequencer.sv
// Bench for sdiv_sequencer: behavioural divider core, spec vector table, directed
// handshake/reset sequences and randomized requests checked against an arithmetic model.
module tb_sdiv_sequencer;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, in_signed;
    logic         core_start, core_busy, core_done, core_valid, core_dbz;
    logic         out_valid, out_ready, out_dbz;
    logic [W-1:0] in_a, in_b, core_a, core_b, core_val, core_rem, out_quo, out_rem;
`ifdef SDIV_OVF_CHECK_EN
    logic         out_ovf;
`endif

    sdiv_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_signed  (in_signed),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_busy  (core_busy),
        .core_done  (core_done),
        .core_valid (core_valid),
        .core_dbz   (core_dbz),
        .core_val   (core_val),
        .core_rem   (core_rem),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_quo    (out_quo),
        .out_rem    (out_rem),
        .out_dbz    (out_dbz)
`ifdef SDIV_OVF_CHECK_EN
        ,
        .out_ovf    (out_ovf)
`endif
    );

    // Behavioural unsigned divider: answers cur_lat cycles after core_start.
    int           cur_lat = 1;
    int           cnt = 0;
    logic         mdone = 1'b0;
    logic         spur_done = 1'b0;
    logic [W-1:0] pa = '0, pb = '0;
    int           start_cnt = 0, drift_cnt = 0, dbl_start = 0;
    logic         prev_start = 1'b0;
    logic [W-1:0] cap_a = '0, cap_b = '0;

    assign core_done  = mdone | spur_done;
    assign core_valid = mdone;
    assign core_busy  = (cnt != 0);
    assign core_dbz   = (pb == 0);
    assign core_val   = (pb == 0) ? '1 : pa / pb;
    assign core_rem   = (pb == 0) ? pa : pa % pb;

    always @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= 0;
            mdone <= 1'b0;
        end else begin
            mdone <= 1'b0;
            if (core_start) begin
                cnt <= cur_lat;
                pa  <= core_a;
                pb  <= core_b;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) mdone <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        prev_start <= core_start;
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            cap_a     <= core_a;
            cap_b     <= core_b;
            if (prev_start) dbl_start <= dbl_start + 1;
        end
        if (mdone && (core_a !== cap_a || core_b !== cap_b)) drift_cnt <= drift_cnt + 1;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division, C-style truncation toward zero.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dbz, output logic ovf,
                                    output logic [W-1:0] ma, output logic [W-1:0] mb);
        longint sa, sb;
        sa  = s ? longint'($signed(a)) : longint'(a);
        sb  = s ? longint'($signed(b)) : longint'(b);
        ma  = W'((sa < 0) ? -sa : sa);
        mb  = W'((sb < 0) ? -sb : sb);
        dbz = (b == 0);
        ovf = 1'b0;
        if (dbz) begin
            q = '1;
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
`ifdef SDIV_OVF_CHECK_EN
        if (s && a == 16'h8000 && b == 16'hFFFF) begin
            ovf = 1'b1;
            q   = 16'h8000;
            r   = '0;
        end
`endif
    endfunction

    task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, input int lat, input int hold,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                           input logic eovf, input logic [W-1:0] eca, input logic [W-1:0] ecb);
        int k, s0, d0;
        cur_lat = lat;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " in_ready"}, in_ready, 1);
        s0 = start_cnt;
        d0 = drift_cnt;
        in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); in_signed = 1'($urandom);
        k = 1;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, k, eovf ? 2 : lat + 4);
        repeat (hold) @(negedge clk);
        chk({tag, " quo"}, out_quo, eq);
        chk({tag, " rem"}, out_rem, er);
        chk({tag, " dbz"}, out_dbz, edbz);
`ifdef SDIV_OVF_CHECK_EN
        chk({tag, " ovf"}, out_ovf, eovf);
`endif
        chk({tag, " starts"}, start_cnt - s0, eovf ? 0 : 1);
        if (!eovf) begin
            chk({tag, " core_a"}, cap_a, eca);
            chk({tag, " core_b"}, cap_b, ecb);
        end
        chk({tag, " operand drift"}, drift_cnt - d0, 0);
        chk({tag, " start pulse"}, dbl_start, 0);
        $display("txn %s a=%h b=%h s=%0d lat=%0d -> quo=%h rem=%h dbz=%0d (exp %h %h %0d)",
                 tag, a, b, s, lat, out_quo, out_rem, out_dbz, eq, er, edbz);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid drop"}, out_valid, 0);
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         s;
        logic [W-1:0] q, r;
        logic         dbz, ovf;
        logic [W-1:0] ca, cb;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [W-1:0] q, r, ma, mb, a, b;
        logic         dbz, ovf, s;
        int           seen, k;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst core_start", core_start, 0);
        chk("rst out_dbz", out_dbz, 0);
        chk("rst out_quo", out_quo, 0);
        chk("rst out_rem", out_rem, 0);
        chk("rst core_a", core_a, 0);
        chk("rst core_b", core_b, 0);
`ifdef SDIV_OVF_CHECK_EN
        chk("rst out_ovf", out_ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", in_ready, 1);

        vecs[0] = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 16'h0007, 16'h0002};
        vecs[1] = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 16'h0007, 16'h0002};
        vecs[2] = '{16'hFFFF, 16'h0010, 1'b0, 16'h0FFF, 16'h000F, 1'b0, 1'b0, 16'hFFFF, 16'h0010};
        vecs[3] = '{16'h0064, 16'h0000, 1'b0, 16'hFFFF, 16'h0064, 1'b1, 1'b0, 16'h0064, 16'h0000};
        vecs[4] = '{16'h0064, 16'h0000, 1'b1, 16'hFFFF, 16'h0064, 1'b1, 1'b0, 16'h0064, 16'h0000};
        vecs[5] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0, 16'h8000, 16'h0001};
        vecs[6] = '{16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 16'h0007, 16'h0002};
        vecs[7] = '{16'h8000, 16'h0000, 1'b1, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 16'h8000, 16'h0000};
`ifdef SDIV_OVF_CHECK_EN
        vecs[5].ovf = 1'b1;
`endif
        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, 1 + (i % 3), i % 2,
                    vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, vecs[i].ca, vecs[i].cb);
        end

        // Stalled output: stable results, no second acceptance, spurious core_done ignored.
        cur_lat = 2;
        in_a = 16'd100; in_b = 16'd7; in_signed = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("stall reached hold", out_valid, 1);
        seen = start_cnt;
        in_a = 16'd45; in_b = 16'd9; in_signed = 1'b0; in_valid = 1'b1;
        spur_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            spur_done = 1'b0;
            chk($sformatf("stall%0d quo", i), out_quo, 16'd14);
            chk($sformatf("stall%0d rem", i), out_rem, 16'd2);
            chk($sformatf("stall%0d in_ready", i), in_ready, 0);
            chk($sformatf("stall%0d out_valid", i), out_valid, 1);
        end
        chk("stall no new start", start_cnt - seen, 0);
        $display("txn stall a=0064 b=0007 held 5 cycles quo=%h rem=%h", out_quo, out_rem);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle after handshake in_ready", in_ready, 1);
        chk("idle after handshake out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("queued request accepted", in_ready, 0);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("queued quo", out_quo, 16'd5);
        chk("queued rem", out_rem, 16'd0);
        $display("txn queued a=002d b=0009 quo=%h rem=%h", out_quo, out_rem);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // core_done while idle must not produce a result.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle done ignored out_valid", out_valid, 0);
        chk("idle done ignored in_ready", in_ready, 1);

        // Reset while the divider is busy discards the request.
        cur_lat = 10;
        in_a = 16'h1234; in_b = 16'h0011; in_signed = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset in_ready", in_ready, 0);
        chk("mid reset out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after mid reset", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no result after reset", seen, 0);
        $display("txn reset-during-wait a=1234 b=0011 discarded");
        ref_div(16'h0FA0, 16'hFFF6, 1'b1, q, r, dbz, ovf, ma, mb);
        run_txn("post-reset", 16'h0FA0, 16'hFFF6, 1'b1, 3, 0, q, r, dbz, ovf, ma, mb);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       b = '0;
                1: begin a = 16'h8000; b = 16'hFFFF; s = 1'b1; end
                2, 3:    b = W'($urandom_range(1, 20));
                4:       b = W'(-$urandom_range(1, 20));
                default: b = W'($urandom);
            endcase
            ref_div(a, b, s, q, r, dbz, ovf, ma, mb);
            run_txn($sformatf("rnd%0d", i), a, b, s, $urandom_range(1, 5), $urandom_range(0, 3),
                    q, r, dbz, ovf, ma, mb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdiv_sequencer.md
SDIV_SEQUENCER -- requirements
Module: sdiv_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand/result width in bits (>=2).
REQ-002 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have in_valid  input  1 and in_ready  output  1  request handshake.
REQ-005 SHALL have in_a  input  WIDTH (dividend), in_b  input  WIDTH (divisor) and in_signed  input  1 (1 = two's-complement operands).
REQ-006 SHALL have core_start  output  1, core_a  output  WIDTH and core_b  output  WIDTH  unsigned divider command.
REQ-007 SHALL have core_busy, core_done, core_valid, core_dbz  input  1 each; core_val and core_rem  input  WIDTH  divider status and results.
REQ-008 SHALL have out_valid  output  1 and out_ready  input  1  result handshake.
REQ-009 SHALL have out_quo  output  WIDTH, out_rem  output  WIDTH and out_dbz  output  1  result.

Function
REQ-010 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> FIXUP -> HOLD -> IDLE.
REQ-011 SHALL drive in_ready high only in IDLE; in IDLE, in_valid&in_ready latches in_a, in_b and in_signed and moves to LAUNCH.
REQ-012 In LAUNCH, SHALL pulse core_start for exactly one cycle with core_a/core_b = operand magnitudes, then move to WAIT.
REQ-013 Magnitude: |x| when in_signed and x[WIDTH-1]=1, else x; |MIN| = 2^(WIDTH-1) as an unsigned value.
REQ-014 SHALL hold core_a/core_b stable from LAUNCH until leaving WAIT.
REQ-015 In WAIT, on core_done SHALL capture core_val, core_rem and core_dbz and move to FIXUP; core_done in any other state SHALL be ignored.
REQ-016 In FIXUP, signed results SHALL be computed: quotient negated iff the operand signs differ (truncation toward zero); remainder negated iff the dividend is negative.
REQ-017 For dbz, SHALL set out_quo = all ones, out_rem = original in_a and out_dbz = 1, regardless of in_signed.
REQ-018 SHALL register outputs on FIXUP -> HOLD; out_valid is high only in HOLD.
REQ-019 SHALL hold out_quo, out_rem and out_dbz stable in HOLD until out_valid&out_ready; that cycle returns to IDLE.
REQ-020 Latency: accept at cycle N, core_start at N+1, out_valid one cycle after FIXUP; FIXUP is the cycle after core_done.
REQ-021 SHALL allow at most one request in flight; in_valid while in_ready=0 SHALL have no effect.

Reset
REQ-022 On rst_n=0, SHALL force state IDLE and drive in_ready=0, core_start=0, out_valid=0, out_dbz=0, and out_quo, out_rem, core_a and core_b = 0.
REQ-023 Reset mid-operation (any state) SHALL discard the request; no out_valid follows; the divider shares rst_n.
REQ-024 in_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-025 SHALL support macro SDIV_OVF_CHECK_EN, which adds output out_ovf (1 bit, reset 0).
REQ-026 With SDIV_OVF_CHECK_EN, a signed MIN / -1 request SHALL bypass LAUNCH/WAIT (no core_start), go directly to FIXUP, and produce out_quo=MIN, out_rem=0, out_ovf=1.
REQ-027 Without SDIV_OVF_CHECK_EN, MIN / -1 SHALL run through the divider and yield out_quo=MIN, out_rem=0 by wrap, with no out_ovf port.

Structure
REQ-028 Package sdiv_pkg SHALL hold the FSM state enum and a result struct {quo, rem, dbz, ovf}.
REQ-029 Sign fix-up SHALL be a combinational sub-module sdiv_sign_fix (magnitudes + result negation), instantiated once.

Verification (WIDTH=16)
REQ-030 Signed -7/2 (0xFFF9/0x0002) -> core_a=7, core_b=2; out_quo=0xFFFD, out_rem=0xFFFF, out_dbz=0.
REQ-031 Signed 7/-2 -> out_quo=0xFFFD, out_rem=0x0001; unsigned 0xFFFF/0x0010 -> out_quo=0x0FFF, out_rem=0x000F.
REQ-032 0x0064/0 (either mode) -> out_dbz=1, out_quo=0xFFFF, out_rem=0x0064.
REQ-033 Signed 0x8000/0xFFFF -> with macro: no core_start, out_ovf=1, out_quo=0x8000, out_rem=0; without macro: core_a=0x8000, core_b=1, out_quo=0x8000, out_rem=0.
REQ-034 out_ready held low 5 cycles in HOLD -> outputs stable, in_ready=0, second in_valid ignored; accepted on the first IDLE cycle after handshake.
REQ-035 rst_n pulsed during WAIT -> out_valid never asserts; in_ready=1 the cycle after release; next request completes correctly.
